ls_queue: RTL and testbench
===========================

# ls_queue

Parametrised load/store queue that succeeds the single-issue load/store buffer between issue logic and the data-memory port. Entries are allocated in program order, snoop the CDB for address and store-data operands, and compute the effective address internally. Stores write to memory in order from the oldest entry. Loads may bypass older stores once memory disambiguation clears them, and can optionally take their data directly from a matching older store.

## Interface
- DEPTH_POW2, 3, log2 of entry count; DEPTH = 2**DEPTH_POW2; must not exceed the length of LS_RS_STATION.
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- write_i  in  1  allocate one entry this cycle; ignored when full_o is high.
- load_i  in  1  1 = load, 0 = store.
- addr_tag_i / addr_i / offset_i  in  rs_tag_t / word32_t / word32_t  base operand (tag or value) and immediate offset.
- data_st_tag_i / data_st_i  in  rs_tag_t / word32_t  store-data operand; don't-care for loads.
- cdb_i  in  cdb_t  common data bus snoop.
- cdb_term_o  out  cdb_t  load result broadcast; tag = NO_VAL when idle.
- full_o  out  1  count == DEPTH.
- tag_alloc_o  out  rs_tag_t  LS_RS_STATION[tail], the tag the next allocated entry will carry.
- dmem_rd_data_i  in  word32_t  read data, valid while dmem_done_i is high.
- dmem_done_i  in  1  completes the current request.
- dmem_read_o / dmem_write_o  out  1  request strobes.
- dmem_addr_o / dmem_data_o  out  word32_t  request address and write data.

## Operation
- Circular buffer with head (oldest), tail (next free) and a count register DEPTH_POW2+1 bits wide. Slot i carries the fixed tag LS_RS_STATION[i].
- Per-entry state: valid, load, addr_tag, addr, offset, data_st_tag, data_st, issued, done.
- Effective address: eff = addr + offset, mod 2^32. Address match compares all 32 bits.
- Operand capture:
  - A CDB tag != NO_VAL that equals an entry's addr_tag or data_st_tag captures cdb_i.val and sets that tag field to NO_VAL.
  - Allocation applies the same match to addr_tag_i and data_st_tag_i in the same cycle.
- Store eligibility: the store is at head, both tags are NO_VAL, and the entry is not issued.
- Load eligibility, all required:
  - addr_tag is NO_VAL and the entry is not issued.
  - Every older valid store has addr_tag == NO_VAL.
  - No older valid store has an eff address equal to the load's.
- Selection runs only when the memory port is idle. An eligible head store has priority; otherwise the oldest eligible load is selected.
- Retire: the head entry is freed when done is set, at most one entry per cycle. Allocation and retire may occur in the same cycle, and count is then unchanged.
- Pointers wrap modulo DEPTH.

## Timing
- Reset: head = tail = 0 and count = 0. All valid, issued and done bits clear. dmem_read_o = dmem_write_o = 0, dmem_addr_o = dmem_data_o = 0, cdb_term_o.tag = NO_VAL, full_o = 0.
- An entry allocated at edge N can be selected at edge N+1 at the earliest. Its strobe rises in the cycle after selection.
- Strobe, address and data are held stable until dmem_done_i is sampled high, and drop in the following cycle. Only one request is outstanding at a time.
- Load completion: dmem_done_i sampled high at edge N causes cdb_term_o = {tag, rd_data} for exactly the cycle after N, and sets done.
- Store completion: dmem_done_i sets done, with no broadcast.
- Full: write_i while full_o is high is dropped, with no state change. A same-cycle retire does not lift full_o until the next cycle.
- A reset assertion mid-request deasserts the strobes asynchronously. A dmem_done_i arriving after reset releases is ignored.
- A CDB match and an allocation in the same cycle both take effect.

## Configuration
- LSQ_FWD_EN defined: store-to-load forwarding is enabled.
  - A load whose only blocker is an address match is eligible if the youngest older matching store has data_st_tag == NO_VAL.
  - The load then broadcasts that store's data_st on cdb_term_o one cycle after selection, with no dmem access, and is marked done.
  - Forwarding is suppressed in any cycle where a memory load result is being broadcast.
- LSQ_FWD_EN undefined: a matching load waits until the matching store retires.

## Test plan
- Reset and allocate: reset, then allocate 8 loads with addr_i = 0x100, offset_i = 4, tags ready -> dmem_addr_o = 0x104 eight times; each broadcast carries LS_RS_STATION[i]; full_o = 1 after the 8th write_i.
- Load bypass: store to 0x200 (data tag pending), then load from 0x300 -> load issues first with dmem_read_o and dmem_addr_o = 0x300; the store writes only after a CDB broadcast of its data tag supplies 0xDEAD.
- Disambiguation stall: older store addr_tag pending, younger load ready -> no dmem_read_o until the CDB resolves the store address.
- Forwarding:
  - With LSQ_FWD_EN: store 0xCAFE to 0x40, then load from 0x40 -> cdb_term_o.val = 0xCAFE with no dmem_read_o.
  - Without LSQ_FWD_EN: the load is read from memory after the store's dmem_write_o completes.
- Wrap and simultaneous events: hold count at 8, retire head and drive write_i in the same cycle -> write dropped; next cycle write accepted into slot 0 after wrap. A CDB match on addr_tag_i during allocation captures the value.
- Reset mid-request: assert reset_ni low while dmem_read_o = 1 -> strobe 0 immediately; a late dmem_done_i produces no broadcast.

Source files
------------

// File: rtl/ls_queue.sv
// ls_queue: in-order-allocated load/store queue between issue logic and the data-memory port.
// Define LSQ_FWD_EN to let a load take its data directly from a matching older store.

package ls_queue_pkg;
    typedef logic [31:0] word32_t;
    typedef logic [4:0]  rs_tag_t;

    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;

    localparam rs_tag_t NO_VAL    = 5'd0;
    localparam int      LS_RS_LEN = 8;
    // Reservation-station tags owned by the queue; slot i always broadcasts as entry [i].
    localparam rs_tag_t [LS_RS_LEN-1:0] LS_RS_STATION = {
        5'd23, 5'd22, 5'd21, 5'd20, 5'd19, 5'd18, 5'd17, 5'd16
    };
endpackage

module ls_queue
    import ls_queue_pkg::*;
#(
    parameter int DEPTH_POW2 = 3
) (
    input  logic    clk_i,
    input  logic    reset_ni,
    input  logic    write_i,
    input  logic    load_i,
    input  rs_tag_t addr_tag_i,
    input  word32_t addr_i,
    input  word32_t offset_i,
    input  rs_tag_t data_st_tag_i,
    input  word32_t data_st_i,
    input  cdb_t    cdb_i,
    output cdb_t    cdb_term_o,
    output logic    full_o,
    output rs_tag_t tag_alloc_o,
    input  word32_t dmem_rd_data_i,
    input  logic    dmem_done_i,
    output logic    dmem_read_o,
    output logic    dmem_write_o,
    output word32_t dmem_addr_o,
    output word32_t dmem_data_o
);
    localparam int DEPTH = 2 ** DEPTH_POW2;

    typedef logic [DEPTH_POW2-1:0] ptr_t;
    typedef logic [DEPTH_POW2:0]   cnt_t;

    typedef struct packed {
        logic    valid;
        logic    load;
        rs_tag_t addr_tag;
        word32_t addr;
        word32_t offset;
        rs_tag_t data_st_tag;
        word32_t data_st;
        logic    issued;
        logic    done;
    } entry_t;

    typedef enum logic [1:0] {PORT_IDLE, PORT_READ, PORT_WRITE} port_e;

    entry_t  entries_q [DEPTH];
    entry_t  entries_d [DEPTH];
    word32_t eff [DEPTH];
    ptr_t    head_q, head_d, tail_q, tail_d;
    cnt_t    count_q, count_d;
    port_e   port_q, port_d;
    ptr_t    req_idx_q, req_idx_d;
    word32_t req_addr_q, req_addr_d, req_data_q, req_data_d;
    cdb_t    term_q, term_d;

    logic    sel_found, ld_ok, blocked, match, alloc, retire;
    ptr_t    sel_idx, idx, jdx;
`ifdef LSQ_FWD_EN
    logic    mem_bcast_q, mem_bcast_d, sel_fwd, match_ready;
    word32_t match_data, fwd_data;
`endif

    assign full_o       = (count_q == cnt_t'(DEPTH));
    assign tag_alloc_o  = LS_RS_STATION[tail_q];
    assign cdb_term_o   = term_q;
    assign dmem_read_o  = (port_q == PORT_READ);
    assign dmem_write_o = (port_q == PORT_WRITE);
    assign dmem_addr_o  = req_addr_q;
    assign dmem_data_o  = req_data_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) eff[i] = entries_q[i].addr + entries_q[i].offset;
    end

    always_comb begin
        entries_d  = entries_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        port_d     = port_q;
        req_idx_d  = req_idx_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        term_d     = '{tag: NO_VAL, val: '0};
        sel_found  = 1'b0;
        sel_idx    = '0;
        idx        = '0;
        jdx        = '0;
        ld_ok      = 1'b0;
        blocked    = 1'b0;
        match      = 1'b0;
`ifdef LSQ_FWD_EN
        mem_bcast_d = 1'b0;
        sel_fwd     = 1'b0;
        match_ready = 1'b0;
        match_data  = '0;
        fwd_data    = '0;
`endif
        alloc  = write_i && !full_o;
        retire = entries_q[head_q].valid && entries_q[head_q].done;

        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_i.tag != NO_VAL && entries_q[i].addr_tag == cdb_i.tag) begin
                entries_d[i].addr     = cdb_i.val;
                entries_d[i].addr_tag = NO_VAL;
            end
            if (cdb_i.tag != NO_VAL && entries_q[i].data_st_tag == cdb_i.tag) begin
                entries_d[i].data_st     = cdb_i.val;
                entries_d[i].data_st_tag = NO_VAL;
            end
        end

        if (port_q != PORT_IDLE && dmem_done_i) begin
            entries_d[req_idx_q].done = 1'b1;
            if (port_q == PORT_READ) begin
                term_d = '{tag: LS_RS_STATION[req_idx_q], val: dmem_rd_data_i};
`ifdef LSQ_FWD_EN
                mem_bcast_d = 1'b1;
`endif
            end
            port_d     = PORT_IDLE;
            req_addr_d = '0;
            req_data_d = '0;
        end

        // Head store wins; otherwise scan from the head for the oldest load clear of older stores.
        if (port_q == PORT_IDLE) begin
            if (entries_q[head_q].valid && !entries_q[head_q].load && !entries_q[head_q].issued &&
                entries_q[head_q].addr_tag == NO_VAL && entries_q[head_q].data_st_tag == NO_VAL) begin
                sel_found = 1'b1;
                sel_idx   = head_q;
            end else begin
                for (int k = 0; k < DEPTH; k++) begin
                    idx     = ptr_t'(head_q + k);
                    ld_ok   = entries_q[idx].valid && entries_q[idx].load &&
                              !entries_q[idx].issued && entries_q[idx].addr_tag == NO_VAL;
                    blocked = 1'b0;
                    match   = 1'b0;
`ifdef LSQ_FWD_EN
                    match_ready = 1'b0;
                    match_data  = '0;
`endif
                    for (int j = 0; j < k; j++) begin
                        jdx = ptr_t'(head_q + j);
                        if (entries_q[jdx].valid && !entries_q[jdx].load) begin
                            if (entries_q[jdx].addr_tag != NO_VAL) begin
                                blocked = 1'b1;
                            end else if (eff[jdx] == eff[idx]) begin
                                match = 1'b1;
`ifdef LSQ_FWD_EN
                                match_ready = (entries_q[jdx].data_st_tag == NO_VAL);
                                match_data  = entries_q[jdx].data_st;
`endif
                            end
                        end
                    end
                    if (!sel_found && ld_ok && !blocked) begin
                        if (!match) begin
                            sel_found = 1'b1;
                            sel_idx   = idx;
                        end
`ifdef LSQ_FWD_EN
                        else if (match_ready && !mem_bcast_q) begin
                            sel_found = 1'b1;
                            sel_idx   = idx;
                            sel_fwd   = 1'b1;
                            fwd_data  = match_data;
                        end
`endif
                    end
                end
            end
        end

        if (sel_found) begin
            entries_d[sel_idx].issued = 1'b1;
`ifdef LSQ_FWD_EN
            if (sel_fwd) begin
                entries_d[sel_idx].done = 1'b1;
                term_d = '{tag: LS_RS_STATION[sel_idx], val: fwd_data};
            end else
`endif
            begin
                port_d     = entries_q[sel_idx].load ? PORT_READ : PORT_WRITE;
                req_idx_d  = sel_idx;
                req_addr_d = eff[sel_idx];
                req_data_d = entries_q[sel_idx].load ? '0 : entries_q[sel_idx].data_st;
            end
        end

        if (retire) begin
            entries_d[head_q] = '0;
            head_d            = head_q + ptr_t'(1);
        end

        // A producer finishing in the allocation cycle is captured straight from the CDB.
        if (alloc) begin
            entries_d[tail_q].valid       = 1'b1;
            entries_d[tail_q].load        = load_i;
            entries_d[tail_q].offset      = offset_i;
            entries_d[tail_q].issued      = 1'b0;
            entries_d[tail_q].done        = 1'b0;
            entries_d[tail_q].addr_tag    = addr_tag_i;
            entries_d[tail_q].addr        = addr_i;
            entries_d[tail_q].data_st_tag = data_st_tag_i;
            entries_d[tail_q].data_st     = data_st_i;
            if (cdb_i.tag != NO_VAL && addr_tag_i == cdb_i.tag) begin
                entries_d[tail_q].addr_tag = NO_VAL;
                entries_d[tail_q].addr     = cdb_i.val;
            end
            if (cdb_i.tag != NO_VAL && data_st_tag_i == cdb_i.tag) begin
                entries_d[tail_q].data_st_tag = NO_VAL;
                entries_d[tail_q].data_st     = cdb_i.val;
            end
            tail_d = tail_q + ptr_t'(1);
        end

        case ({alloc, retire})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            port_q     <= PORT_IDLE;
            req_idx_q  <= '0;
            req_addr_q <= '0;
            req_data_q <= '0;
            term_q     <= '{tag: NO_VAL, val: '0};
`ifdef LSQ_FWD_EN
            mem_bcast_q <= 1'b0;
`endif
        end else begin
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            port_q     <= port_d;
            req_idx_q  <= req_idx_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            term_q     <= term_d;
`ifdef LSQ_FWD_EN
            mem_bcast_q <= mem_bcast_d;
`endif
        end
    end
endmodule

// File: tb/tb_ls_queue.sv
// tb_ls_queue: directed scoreboard bench for ls_queue; stimulus queues expected memory
// requests and result broadcasts, independent monitors pop and compare them.

module tb_ls_queue;
    import ls_queue_pkg::*;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] val;
    } bc_t;

    logic    clk_i, reset_ni, write_i, load_i;
    rs_tag_t addr_tag_i, data_st_tag_i, tag_alloc_o;
    word32_t addr_i, offset_i, data_st_i, dmem_rd_data_i, dmem_addr_o, dmem_data_o;
    cdb_t    cdb_i, cdb_term_o;
    logic    full_o, dmem_done_i, dmem_read_o, dmem_write_o;

    req_t        exp_req [$];
    bc_t         exp_bc [$];
    int          compared, mismatched;
    logic        mem_en;
    int          force_req;
    logic [31:0] mem [logic [31:0]];

    localparam int MEM_LAT = 2;

    ls_queue #(.DEPTH_POW2(3)) dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .write_i        (write_i),
        .load_i         (load_i),
        .addr_tag_i     (addr_tag_i),
        .addr_i         (addr_i),
        .offset_i       (offset_i),
        .data_st_tag_i  (data_st_tag_i),
        .data_st_i      (data_st_i),
        .cdb_i          (cdb_i),
        .cdb_term_o     (cdb_term_o),
        .full_o         (full_o),
        .tag_alloc_o    (tag_alloc_o),
        .dmem_rd_data_i (dmem_rd_data_i),
        .dmem_done_i    (dmem_done_i),
        .dmem_read_o    (dmem_read_o),
        .dmem_write_o   (dmem_write_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_data_o    (dmem_data_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic ld, input rs_tag_t atag, input word32_t a,
                                  input word32_t off, input rs_tag_t dtag, input word32_t d);
        write_i       = 1'b1;
        load_i        = ld;
        addr_tag_i    = atag;
        addr_i        = a;
        offset_i      = off;
        data_st_tag_i = dtag;
        data_st_i     = d;
        @(negedge clk_i);
        write_i       = 1'b0;
        addr_tag_i    = 5'd0;
        data_st_tag_i = 5'd0;
    endtask

    task automatic send_cdb(input rs_tag_t tag, input word32_t val);
        cdb_i = '{tag: tag, val: val};
        @(negedge clk_i);
        cdb_i = '{tag: 5'd0, val: 32'h0};
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_req.size() != 0 || exp_bc.size() != 0) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        repeat (3) @(negedge clk_i);
        check_output({name, "_pending_req"}, 32'(exp_req.size()), 32'd0);
        check_output({name, "_pending_bc"}, 32'(exp_bc.size()), 32'd0);
        exp_req.delete();
        exp_bc.delete();
    endtask

    // Memory model: fixed latency, writes stored, unwritten reads return addr ^ 0xA5A50000.
    initial begin
        int wait_cnt;
        int force_ack;
        wait_cnt       = 0;
        force_ack      = 0;
        dmem_done_i    = 1'b0;
        dmem_rd_data_i = 32'h0;
        forever begin
            @(negedge clk_i);
            if (dmem_done_i) begin
                dmem_done_i    = 1'b0;
                dmem_rd_data_i = 32'h0;
                wait_cnt       = 0;
            end else if (force_req != force_ack) begin
                force_ack      = force_req;
                dmem_done_i    = 1'b1;
                dmem_rd_data_i = 32'h0BAD_0BAD;
            end else if ((dmem_read_o || dmem_write_o) && mem_en) begin
                wait_cnt++;
                if (wait_cnt >= MEM_LAT) begin
                    dmem_done_i = 1'b1;
                    if (dmem_write_o) mem[dmem_addr_o] = dmem_data_o;
                    else dmem_rd_data_i = mem.exists(dmem_addr_o) ? mem[dmem_addr_o]
                                                                  : (dmem_addr_o ^ 32'hA5A5_0000);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every new memory request and every result broadcast is matched against the queues.
    initial begin
        logic prev_active;
        req_t r;
        bc_t  b;
        prev_active = 1'b0;
        forever begin
            @(negedge clk_i);
            if ((dmem_read_o || dmem_write_o) && !prev_active) begin
                if (exp_req.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_req: got wr=%0b addr=0x%08h, expected no request",
                             dmem_write_o, dmem_addr_o);
                end else begin
                    r = exp_req.pop_front();
                    check_output("req_write", 32'(dmem_write_o), 32'(r.wr));
                    check_output("req_addr", dmem_addr_o, r.addr);
                    if (r.wr) check_output("req_data", dmem_data_o, r.data);
                end
            end
            prev_active = dmem_read_o || dmem_write_o;
            if (cdb_term_o.tag != 5'd0) begin
                if (exp_bc.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_bc: got tag=%0d val=0x%08h, expected no broadcast",
                             cdb_term_o.tag, cdb_term_o.val);
                end else begin
                    b = exp_bc.pop_front();
                    check_output("bc_tag", 32'(cdb_term_o.tag), 32'(b.tag));
                    check_output("bc_val", cdb_term_o.val, b.val);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        compared      = 0;
        mismatched    = 0;
        mem_en        = 1'b0;
        force_req     = 0;
        reset_ni      = 1'b0;
        write_i       = 1'b0;
        load_i        = 1'b0;
        addr_tag_i    = 5'd0;
        addr_i        = 32'h0;
        offset_i      = 32'h0;
        data_st_tag_i = 5'd0;
        data_st_i     = 32'h0;
        cdb_i         = '{tag: 5'd0, val: 32'h0};

        repeat (2) @(negedge clk_i);
        $display("[TB] reset state");
        check_output("rst_full", 32'(full_o), 32'd0);
        check_output("rst_read", 32'(dmem_read_o), 32'd0);
        check_output("rst_write", 32'(dmem_write_o), 32'd0);
        check_output("rst_addr", dmem_addr_o, 32'h0);
        check_output("rst_data", dmem_data_o, 32'h0);
        check_output("rst_term_tag", 32'(cdb_term_o.tag), 32'd0);
        check_output("rst_tag_alloc", 32'(tag_alloc_o), 32'd16);
        reset_ni = 1'b1;
        @(negedge clk_i);

        $display("[TB] fill, full drop, wrap and capture on allocation");
        for (int i = 0; i < 8; i++) begin
            exp_req.push_back('{wr: 1'b0, addr: 32'h0000_0104, data: 32'h0});
            exp_bc.push_back('{tag: 5'(16 + i), val: 32'hA5A5_0104});
            apply_stimulus(1'b1, 5'd0, 32'h100, 32'h4, 5'd0, 32'h0);
        end
        check_output("full_after_8", 32'(full_o), 32'd1);
        check_output("tag_alloc_wrapped", 32'(tag_alloc_o), 32'd16);
        mem_en = 1'b1;
        n = 0;
        while (cdb_term_o.tag == 5'd0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check_output("first_bc_tag", 32'(cdb_term_o.tag), 32'd16);
        check_output("full_in_retire_cycle", 32'(full_o), 32'd1);
        apply_stimulus(1'b1, 5'd0, 32'h999, 32'h0, 5'd0, 32'h0);
        check_output("full_lifted", 32'(full_o), 32'd0);
        check_output("tag_alloc_slot0", 32'(tag_alloc_o), 32'd16);
        exp_req.push_back('{wr: 1'b0, addr: 32'h0000_0710, data: 32'h0});
        exp_bc.push_back('{tag: 5'd16, val: 32'hA5A5_0710});
        cdb_i = '{tag: 5'd3, val: 32'h700};
        apply_stimulus(1'b1, 5'd3, 32'h500, 32'h10, 5'd0, 32'h0);
        cdb_i = '{tag: 5'd0, val: 32'h0};
        wait_drain("alloc_wrap");

        $display("[TB] load bypasses store waiting on data");
        do_reset();
        exp_req.push_back('{wr: 1'b0, addr: 32'h0000_0300, data: 32'h0});
        exp_bc.push_back('{tag: 5'd17, val: 32'hA5A5_0300});
        exp_req.push_back('{wr: 1'b1, addr: 32'h0000_0200, data: 32'h0000_DEAD});
        apply_stimulus(1'b0, 5'd0, 32'h200, 32'h0, 5'd5, 32'h0);
        apply_stimulus(1'b1, 5'd0, 32'h300, 32'h0, 5'd0, 32'h0);
        n = 0;
        while (exp_bc.size() != 0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        repeat (3) @(negedge clk_i);
        check_output("store_held_for_data", 32'(dmem_write_o), 32'd0);
        send_cdb(5'd5, 32'h0000_DEAD);
        wait_drain("bypass");

        $display("[TB] load stalls behind store with unknown address");
        do_reset();
        exp_req.push_back('{wr: 1'b1, addr: 32'h0000_0608, data: 32'h0000_1234});
        exp_req.push_back('{wr: 1'b0, addr: 32'h0000_0400, data: 32'h0});
        exp_bc.push_back('{tag: 5'd17, val: 32'hA5A5_0400});
        apply_stimulus(1'b0, 5'd6, 32'h0, 32'h8, 5'd0, 32'h0000_1234);
        apply_stimulus(1'b1, 5'd0, 32'h400, 32'h0, 5'd0, 32'h0);
        repeat (5) @(negedge clk_i);
        check_output("disamb_no_read", 32'(dmem_read_o), 32'd0);
        check_output("disamb_no_write", 32'(dmem_write_o), 32'd0);
        send_cdb(5'd6, 32'h600);
        wait_drain("disamb");

        $display("[TB] store then load to the same address");
        do_reset();
        exp_req.push_back('{wr: 1'b1, addr: 32'h0000_0040, data: 32'h0000_CAFE});
`ifndef LSQ_FWD_EN
        exp_req.push_back('{wr: 1'b0, addr: 32'h0000_0040, data: 32'h0});
`endif
        exp_bc.push_back('{tag: 5'd17, val: 32'h0000_CAFE});
        apply_stimulus(1'b0, 5'd0, 32'h40, 32'h0, 5'd0, 32'h0000_CAFE);
        apply_stimulus(1'b1, 5'd0, 32'h40, 32'h0, 5'd0, 32'h0);
        wait_drain("same_addr");

        $display("[TB] reset during an outstanding read");
        do_reset();
        mem_en = 1'b0;
        exp_req.push_back('{wr: 1'b0, addr: 32'h0000_0800, data: 32'h0});
        apply_stimulus(1'b1, 5'd0, 32'h800, 32'h0, 5'd0, 32'h0);
        n = 0;
        while (!dmem_read_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check_output("midrst_read_up", 32'(dmem_read_o), 32'd1);
        #2 reset_ni = 1'b0;
        #1 check_output("midrst_read_drop", 32'(dmem_read_o), 32'd0);
        check_output("midrst_addr_clear", dmem_addr_o, 32'h0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        force_req++;
        repeat (4) @(negedge clk_i);
        check_output("late_done_no_bc", 32'(cdb_term_o.tag), 32'd0);
        check_output("late_done_no_read", 32'(dmem_read_o), 32'd0);
        wait_drain("midrst");

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
